operand_seq_ctrl: RTL and testbench

Multi-cycle operand-sequencing controller for the 8-bit MK5303 datapath. Accepts one 24-bit instruction at a time and decodes it. It drives the ALU source-select codes for the 34-way operand muxes (32 registers, memory data-out, instruction immediate). Memory-operand loads use a req/rdy handshake with timeout. The block also issues ALU start and register-file write-back strobes.

---
 rtl/mk5303_pkg.sv | 32 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/operand_seq_ctrl.sv | 106 ++++++++++
 tb/tb_operand_seq_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mk5303_pkg.sv
// mk5303_pkg: shared encodings for the MK5303 operand-sequencing controller.
//   Holds the instruction mode codes, the sequencer state enum, the operand
//   mux select codes, the compare opcode and the instruction field positions.
package mk5303_pkg;
    localparam logic [1:0] MODE_RR  = 2'b00;
    localparam logic [1:0] MODE_RI  = 2'b01;
    localparam logic [1:0] MODE_RM  = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_MEMRD,
        ST_EXEC,
        ST_WB
    } state_t;
    localparam logic [5:0] SEL_MEM  = 6'd32;
    localparam logic [5:0] SEL_IMM  = 6'd33;
    localparam logic [5:0] SEL_ZERO = 6'd34;
    localparam logic [3:0] ALUOP_CMP = 4'hF;
    localparam int MODE_HI  = 23;
    localparam int MODE_LO  = 22;
    localparam int ALUOP_HI = 21;
    localparam int ALUOP_LO = 18;
    localparam int RD_HI    = 17;
    localparam int RD_LO    = 13;
    localparam int RS_HI    = 12;
    localparam int RS_LO    = 8;
    localparam int RT_HI    = 4;
    localparam int RT_LO    = 0;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: clear/enable wait counter with a terminal-count flag.
//   clk, rst : clock and asynchronous active-high reset
//   i_clr    : synchronous clear to 0 (wins over i_en)
//   i_en     : count one per cycle
//   o_tc     : high in the enabled cycle whose increment reaches MEM_TIMEOUT
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
    // Flag the last waiting cycle so the controller can leave on the same edge
    // at which the count reaches MEM_TIMEOUT.
    assign o_tc = i_en && (r_cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/operand_seq_ctrl.sv
// operand_seq_ctrl: multi-cycle operand sequencer for the MK5303 datapath.
//   clk, rst                 : clock, asynchronous active-high reset
//   instr_valid/instr_ready  : instruction handshake (ready only in IDLE)
//   instr_word               : {mode, aluop, rd, rs, imm/addr|rt}
//   mem_req/mem_addr/mem_rdy : memory-operand read handshake with timeout
//   src1sel/src2sel          : operand mux codes (0-31 reg, 32 mem, 33 imm, 34 zero)
//   imm_out, alu_op          : latched immediate and ALU opcode
//   alu_start, wb_en/wb_addr : ALU launch and register write-back strobes
//   err                      : one-cycle pulse on illegal mode or memory timeout
//   busy                     : high whenever not IDLE
module operand_seq_ctrl
    import mk5303_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [23:0] instr_word,
    output logic        instr_ready,
    input  logic        mem_rdy,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    output logic [5:0]  src1sel,
    output logic [5:0]  src2sel,
    output logic [7:0]  imm_out,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic        err,
    output logic        busy
);
    state_t      r_state, w_next;
    logic [23:0] r_instr;
    logic [5:0]  r_src1, r_src2, w_src2;
    logic        r_err, w_err, w_tc, w_memrd;
    logic [1:0]  w_mode;
    logic [3:0]  w_aluop;
    assign w_mode  = r_instr[MODE_HI:MODE_LO];
    assign w_aluop = r_instr[ALUOP_HI:ALUOP_LO];
    assign w_memrd = (r_state == ST_MEMRD);
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_memrd),
        .i_en  (w_memrd),
        .o_tc  (w_tc)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end
    // A ready memory beat wins over a timeout occurring in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = instr_valid ? ST_DECODE : ST_IDLE;
            ST_DECODE: w_next = (w_mode == MODE_ILL) ? ST_IDLE :
                                (w_mode == MODE_RM)  ? ST_MEMRD : ST_EXEC;
            ST_MEMRD:  w_next = mem_rdy ? ST_EXEC : w_tc ? ST_IDLE : ST_MEMRD;
            ST_EXEC:   w_next = (w_aluop == ALUOP_CMP) ? ST_IDLE : ST_WB;
            default:   w_next = ST_IDLE;
        endcase
    end
    assign w_src2 = (w_mode == MODE_RR) ? {1'b0, r_instr[RT_HI:RT_LO]} :
                    (w_mode == MODE_RI) ? SEL_IMM :
                    (w_mode == MODE_RM) ? SEL_MEM : SEL_ZERO;
    assign w_err = (r_state == ST_DECODE && w_mode == MODE_ILL) ||
                   (w_memrd && !mem_rdy && w_tc);
    // Selects are loaded on the DECODE exit and parked at zero whenever the
    // sequence returns to IDLE (including the illegal-mode and timeout exits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= '0;
            r_src1  <= SEL_ZERO;
            r_src2  <= SEL_ZERO;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (r_state == ST_IDLE && instr_valid)
                r_instr <= instr_word;
            if (w_next == ST_IDLE) begin
                r_src1 <= SEL_ZERO;
                r_src2 <= SEL_ZERO;
            end else if (r_state == ST_DECODE) begin
                r_src1 <= {1'b0, r_instr[RS_HI:RS_LO]};
                r_src2 <= w_src2;
            end
        end
    end
    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign mem_req     = w_memrd;
    assign mem_addr    = r_instr[IMM_HI:IMM_LO];
    assign imm_out     = r_instr[IMM_HI:IMM_LO];
    assign alu_op      = w_aluop;
    assign alu_start   = (r_state == ST_EXEC);
    assign wb_en       = (r_state == ST_WB);
    assign wb_addr     = r_instr[RD_HI:RD_LO];
    assign src1sel     = r_src1;
    assign src2sel     = r_src2;
    assign err         = r_err;
endmodule

// File: tb/tb_operand_seq_ctrl.sv
// tb_operand_seq_ctrl: directed table-driven bench for operand_seq_ctrl.
module tb_operand_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [23:0] instr_word = '0;
    logic        instr_ready;
    logic        mem_rdy = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [5:0]  src1sel, src2sel;
    logic [7:0]  imm_out;
    logic [3:0]  alu_op;
    logic        alu_start, wb_en, err, busy;
    logic [4:0]  wb_addr;
    int n_vec = 0;
    int n_bad = 0;

    operand_seq_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_word(instr_word),
        .instr_ready(instr_ready), .mem_rdy(mem_rdy), .mem_req(mem_req),
        .mem_addr(mem_addr), .src1sel(src1sel), .src2sel(src2sel),
        .imm_out(imm_out), .alu_op(alu_op), .alu_start(alu_start),
        .wb_en(wb_en), .wb_addr(wb_addr), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // rdy_delay: MEMRD wait cycles before mem_rdy (-1 = never); cycle numbers
    // count from the handshake cycle 0, -1 meaning the event must not occur.
    typedef struct {
        logic [23:0] word;
        int rdy_delay;
        int alu_c;
        int wb_c;
        int err_c;
        int req_n;
        int rdy_c;
        int s1;
        int s2;
        int wa;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Issue one instruction at the current negedge (IDLE), then follow it
    // until instr_ready returns, leaving the bench ready for a back-to-back issue.
    task automatic run(input vec_t v, input int idx);
        int alu_c = -1, wb_c = -1, err_c = -1, rdy_c = -1;
        int alu_n = 0, wb_n = 0, err_n = 0, req_n = 0;
        int s1 = 0, s2 = 0, wa = 0, op = 0, imm = 0;
        bit addr_ok = 1'b1, busy_ok = 1'b1;
        string p = $sformatf("v%0d", idx);
        chk({p, ".ready_at_issue"}, int'(instr_ready), 1);
        instr_word = v.word;
        instr_valid = 1'b1;
        mem_rdy = 1'b0;
        for (int c = 1; c <= 40 && rdy_c < 0; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr_word = ~v.word;
            mem_rdy = (v.rdy_delay >= 0) && (c == 2 + v.rdy_delay);
            if (alu_start) begin
                alu_n++;
                if (alu_c < 0) begin alu_c = c; s1 = src1sel; s2 = src2sel; op = alu_op; end
            end
            if (wb_en) begin
                wb_n++;
                if (wb_c < 0) begin wb_c = c; wa = wb_addr; end
            end
            if (err) begin
                err_n++;
                if (err_c < 0) err_c = c;
            end
            if (mem_req) begin
                req_n++;
                if (mem_addr != v.word[7:0]) addr_ok = 1'b0;
            end
            if (c == 2) imm = imm_out;
            if (busy == instr_ready) busy_ok = 1'b0;
            if (instr_ready) rdy_c = c;
        end
        mem_rdy = 1'b0;
        chk({p, ".ready_cycle"}, rdy_c, v.rdy_c);
        chk({p, ".alu_start_cycle"}, alu_c, v.alu_c);
        chk({p, ".alu_start_count"}, alu_n, v.alu_c >= 0 ? 1 : 0);
        chk({p, ".wb_en_cycle"}, wb_c, v.wb_c);
        chk({p, ".wb_en_count"}, wb_n, v.wb_c >= 0 ? 1 : 0);
        chk({p, ".err_cycle"}, err_c, v.err_c);
        chk({p, ".err_count"}, err_n, v.err_c >= 0 ? 1 : 0);
        chk({p, ".mem_req_cycles"}, req_n, v.req_n);
        chk({p, ".mem_addr_stable"}, int'(addr_ok), 1);
        chk({p, ".busy_vs_ready"}, int'(busy_ok), 1);
        chk({p, ".imm_out"}, imm, int'(v.word[7:0]));
        chk({p, ".src1_idle"}, int'(src1sel), 34);
        chk({p, ".src2_idle"}, int'(src2sel), 34);
        if (v.alu_c >= 0) begin
            chk({p, ".src1sel"}, s1, v.s1);
            chk({p, ".src2sel"}, s2, v.s2);
            chk({p, ".alu_op"}, op, int'(v.word[21:18]));
        end
        if (v.wb_c >= 0)
            chk({p, ".wb_addr"}, wa, v.wa);
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{{2'b00, 4'd2, 5'd5,  5'd3,  8'd17}, -1,  2,  3, -1,  0,  4,  3, 17,  5};
        vt[1] = '{{2'b01, 4'd1, 5'd9,  5'd7,  8'hA5}, -1,  2,  3, -1,  0,  4,  7, 33,  9};
        vt[2] = '{{2'b10, 4'd3, 5'd12, 5'd31, 8'h40},  3,  6,  7, -1,  4,  8, 31, 32, 12};
        vt[3] = '{{2'b10, 4'd4, 5'd2,  5'd0,  8'h81}, -1, -1, -1, 17, 15, 17,  0,  0,  0};
        vt[4] = '{{2'b10, 4'd5, 5'd30, 5'd4,  8'hFE}, 14, 17, 18, -1, 15, 19,  4, 32, 30};
        vt[5] = '{{2'b10, 4'd6, 5'd1,  5'd2,  8'h00},  0,  3,  4, -1,  1,  5,  2, 32,  1};
        vt[6] = '{{2'b11, 4'd2, 5'd1,  5'd2,  8'h03}, -1, -1, -1,  2,  0,  2,  0,  0,  0};
        vt[7] = '{{2'b00, 4'hF, 5'd6,  5'd1,  8'd2},  -1,  2, -1, -1,  0,  3,  1,  2,  6};
        vt[8] = '{{2'b00, 4'd9, 5'd31, 5'd31, 8'd0},   0,  2,  3, -1,  0,  4, 31,  0, 31};
        repeat (2) @(negedge clk);
        chk("rst.instr_ready", int'(instr_ready), 1);
        chk("rst.busy", int'(busy), 0);
        chk("rst.src1sel", int'(src1sel), 34);
        chk("rst.src2sel", int'(src2sel), 34);
        chk("rst.strobes", int'({mem_req, alu_start, wb_en, err}), 0);
        chk("rst.fields", int'({imm_out, alu_op, mem_addr, wb_addr}), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++)
            run(vt[i], i);
        // Reset asserted asynchronously while a memory read is pending.
        instr_word = {2'b10, 4'd7, 5'd3, 5'd8, 8'h55};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("midrst.mem_req_before", int'(mem_req), 1);
        chk("midrst.src2_before", int'(src2sel), 32);
        #2 rst = 1'b1;
        #1;
        chk("midrst.mem_req", int'(mem_req), 0);
        chk("midrst.src1sel", int'(src1sel), 34);
        chk("midrst.src2sel", int'(src2sel), 34);
        chk("midrst.instr_ready", int'(instr_ready), 1);
        chk("midrst.alu_op", int'(alu_op), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(vt[0], 100);
        run(vt[2], 102);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
